// File: rtl/multi_event_counter.sv
// -----------------------------------------------------------------------------
// multi_event_counter
//   N_CH-channel windowed event counter. An accepted start pulse opens a
//   measurement window of i_window cycles. During the window each channel
//   counts events: high cycles (EDGE=0) or rising edges (EDGE=1). When the
//   window ends, the live counts and overflow flags are copied into snapshot
//   registers and o_done pulses for one cycle. o_count reads the snapshot of
//   the channel chosen by i_sel.
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   i_start   start-window request, only honoured in IDLE with i_window != 0
//   i_stop    abort the running window (no snapshot, no done)
//   i_window  window length in cycles, latched when a start is accepted
//   i_signal  per-channel event inputs, synchronous to clk
//   i_sel     snapshot channel select for o_count
//   o_count   snapshot of channel i_sel, 0 when i_sel >= N_CH (combinational)
//   o_ovf     per-channel overflow flags of the last completed window
//   o_busy    high while a window is running
//   o_done    one-cycle pulse when a new snapshot is valid
// -----------------------------------------------------------------------------
module multi_event_counter #(
    parameter int unsigned N_CH     = 4,
    parameter int unsigned N_BIT    = 12,
    parameter int unsigned WIN_BIT  = 16,
    parameter int unsigned SEL_BIT  = 2,
    parameter int unsigned SATURATE = 1,
    parameter int unsigned EDGE     = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic                 i_stop,
    input  logic [WIN_BIT-1:0]   i_window,
    input  logic [N_CH-1:0]      i_signal,
    input  logic [SEL_BIT-1:0]   i_sel,
    output logic [N_BIT-1:0]     o_count,
    output logic [N_CH-1:0]      o_ovf,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam logic [N_BIT-1:0] CNT_MAX = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    // FSM decode strobes
    logic start_ok;
    logic sample;
    logic last_sample;
    logic abort;

    logic [WIN_BIT-1:0]          win_len_q;
    logic [WIN_BIT-1:0]          timer_q;
    logic [N_CH-1:0]             prev_q;
    logic [N_CH-1:0]             event_c;
    logic [N_CH-1:0][N_BIT-1:0]  cnt_q;
    logic [N_CH-1:0][N_BIT-1:0]  cnt_d;
    logic [N_CH-1:0][N_BIT-1:0]  snap_q;
    logic [N_CH-1:0]             ovf_live_q;
    logic [N_CH-1:0]             ovf_live_d;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and control strobes; abort beats the final sample
    always_comb begin
        state_d     = state_q;
        start_ok    = 1'b0;
        sample      = 1'b0;
        last_sample = 1'b0;
        abort       = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start && (i_window != '0)) begin
                    start_ok = 1'b1;
                    state_d  = COUNT;
                end
            end
            COUNT: begin
                if (i_stop) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else begin
                    sample = 1'b1;
                    if (timer_q == (win_len_q - WIN_BIT'(1))) begin
                        last_sample = 1'b1;
                        state_d     = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Per-channel event detect; history is taken every cycle so a level
    // already high when the window opens is not seen as an edge
    always_comb begin
        event_c = '0;
        for (int k = 0; k < int'(N_CH); k++) begin
            if (EDGE != 0) begin
                event_c[k] = i_signal[k] & ~prev_q[k];
            end else begin
                event_c[k] = i_signal[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
        end else begin
            prev_q <= i_signal;
        end
    end

    // Counter increment with saturate-or-wrap and sticky overflow
    always_comb begin
        cnt_d      = cnt_q;
        ovf_live_d = ovf_live_q;
        for (int k = 0; k < int'(N_CH); k++) begin
            if (event_c[k]) begin
                if (cnt_q[k] == CNT_MAX) begin
                    ovf_live_d[k] = 1'b1;
                    if (SATURATE != 0) begin
                        cnt_d[k] = CNT_MAX;
                    end else begin
                        cnt_d[k] = '0;
                    end
                end else begin
                    cnt_d[k] = cnt_q[k] + N_BIT'(1);
                end
            end
        end
    end

    // Window length latch and sample timer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_len_q <= '0;
            timer_q   <= '0;
        end else if (start_ok) begin
            win_len_q <= i_window;
            timer_q   <= '0;
        end else if (sample) begin
            timer_q <= timer_q + WIN_BIT'(1);
        end
    end

    // Live counters and live overflow flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            ovf_live_q <= '0;
        end else if (start_ok) begin
            cnt_q      <= '0;
            ovf_live_q <= '0;
        end else if (sample) begin
            cnt_q      <= cnt_d;
            ovf_live_q <= ovf_live_d;
        end
    end

    // Snapshot includes the final sample, hence the _d values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_q <= '0;
            o_ovf  <= '0;
        end else if (last_sample) begin
            snap_q <= cnt_d;
            o_ovf  <= ovf_live_d;
        end
    end

    // Busy and done flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_busy <= 1'b0;
            o_done <= 1'b0;
        end else begin
            o_done <= last_sample;
            if (start_ok) begin
                o_busy <= 1'b1;
            end else if (abort || last_sample) begin
                o_busy <= 1'b0;
            end
        end
    end

    // Snapshot readout mux; unmatched selects read 0
    always_comb begin
        o_count = '0;
        for (int k = 0; k < int'(N_CH); k++) begin
            if (i_sel == SEL_BIT'(k)) begin
                o_count = snap_q[k];
            end
        end
    end

endmodule

// File: tb/tb_multi_event_counter.sv
// -----------------------------------------------------------------------------
// tb_multi_event_counter
//   Four instances share one stimulus: level/saturate 12-bit, edge 12-bit,
//   level/saturate 4-bit and level/wrap 4-bit. A transaction-level model keeps
//   unbounded raw event totals per window and derives snapshot/overflow values
//   arithmetically; a compare process checks all outputs every cycle.
// -----------------------------------------------------------------------------
module tb_multi_event_counter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start;
    logic        i_stop;
    logic [15:0] i_window;
    logic [3:0]  i_signal;
    logic [1:0]  i_sel;

    logic [11:0] cnt_lvl;
    logic [11:0] cnt_edge;
    logic [3:0]  cnt_sat;
    logic [3:0]  cnt_wrap;
    logic [3:0]  ovf_w [4];
    logic [3:0]  busy_w;
    logic [3:0]  done_w;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t0      = 0;
    int last_done_cyc = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    multi_event_counter #(.N_BIT(12), .SATURATE(1), .EDGE(0)) u_lvl (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_stop(i_stop),
        .i_window(i_window), .i_signal(i_signal), .i_sel(i_sel),
        .o_count(cnt_lvl), .o_ovf(ovf_w[0]), .o_busy(busy_w[0]), .o_done(done_w[0]));

    multi_event_counter #(.N_BIT(12), .SATURATE(1), .EDGE(1)) u_edge (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_stop(i_stop),
        .i_window(i_window), .i_signal(i_signal), .i_sel(i_sel),
        .o_count(cnt_edge), .o_ovf(ovf_w[1]), .o_busy(busy_w[1]), .o_done(done_w[1]));

    multi_event_counter #(.N_BIT(4), .SATURATE(1), .EDGE(0)) u_sat4 (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_stop(i_stop),
        .i_window(i_window), .i_signal(i_signal), .i_sel(i_sel),
        .o_count(cnt_sat), .o_ovf(ovf_w[2]), .o_busy(busy_w[2]), .o_done(done_w[2]));

    multi_event_counter #(.N_BIT(4), .SATURATE(0), .EDGE(0)) u_wrap4 (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_stop(i_stop),
        .i_window(i_window), .i_signal(i_signal), .i_sel(i_sel),
        .o_count(cnt_wrap), .o_ovf(ovf_w[3]), .o_busy(busy_w[3]), .o_done(done_w[3]));

    // Per-instance configuration
    function automatic int cfg_bits(input int c);
        return (c >= 2) ? 4 : 12;
    endfunction
    function automatic bit cfg_edge(input int c);
        return (c == 1);
    endfunction
    function automatic bit cfg_sat(input int c);
        return (c != 3);
    endfunction

    function automatic logic [31:0] cnt_of(input int c);
        case (c)
            0:       return 32'(cnt_lvl);
            1:       return 32'(cnt_edge);
            2:       return 32'(cnt_sat);
            default: return 32'(cnt_wrap);
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit       m_busy;
    bit       m_done;
    int       m_left;
    int       m_raw  [4][4];
    int       m_snap [4][4];
    bit [3:0] m_ovf  [4];
    bit [3:0] m_prev;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0;
            m_done = 0;
            m_left = 0;
            m_prev = '0;
            for (int c = 0; c < 4; c++) begin
                m_ovf[c] = '0;
                for (int k = 0; k < 4; k++) begin
                    m_raw[c][k]  = 0;
                    m_snap[c][k] = 0;
                end
            end
        end else begin
            m_done = 0;
            if (!m_busy) begin
                if (i_start && i_window != 0) begin
                    m_busy = 1;
                    m_left = int'(i_window);
                    for (int c = 0; c < 4; c++)
                        for (int k = 0; k < 4; k++) m_raw[c][k] = 0;
                end
            end else if (i_stop) begin
                m_busy = 0;
            end else begin
                for (int c = 0; c < 4; c++)
                    for (int k = 0; k < 4; k++)
                        if (cfg_edge(c) ? (i_signal[k] && !m_prev[k]) : i_signal[k])
                            m_raw[c][k]++;
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0;
                    m_done = 1;
                    for (int c = 0; c < 4; c++) begin
                        for (int k = 0; k < 4; k++) begin
                            int mx;
                            mx = (1 << cfg_bits(c)) - 1;
                            m_ovf[c][k] = (m_raw[c][k] > mx);
                            if (m_raw[c][k] <= mx)  m_snap[c][k] = m_raw[c][k];
                            else if (cfg_sat(c))    m_snap[c][k] = mx;
                            else                    m_snap[c][k] = m_raw[c][k] % (mx + 1);
                        end
                    end
                end
            end
            m_prev = i_signal;
        end
    end

    // ---------------- every-cycle compare ----------------
    always begin
        @(negedge clk);
        #2;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("busy[%0d]", c),  32'(busy_w[c]), 32'(m_busy));
            chk($sformatf("done[%0d]", c),  32'(done_w[c]), 32'(m_done));
            chk($sformatf("ovf[%0d]", c),   32'(ovf_w[c]),  32'(m_ovf[c]));
            chk($sformatf("count[%0d] sel%0d", c, i_sel), cnt_of(c), 32'(m_snap[c][i_sel]));
        end
        if (done_w[0] === 1'b1) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [3:0] pat(input int tid, input int i);
        logic [3:0] s;
        s = '0;
        case (tid)
            0: if (i > 0) begin
                   s[0] = 1'b1;
                   s[1] = (i % 2 == 1);
                   s[3] = (i <= 3);
               end
            1: s[0] = ((i / 2) % 2 == 0);
            2: s = 4'hF;
            default: s = 4'($urandom);
        endcase
        return s;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            i_start  = 1'b0;
            i_stop   = 1'b0;
            i_signal = '0;
        end
    endtask

    task automatic do_window(input int w, input int tid, input int stop_at, input bit restart);
        @(negedge clk);
        i_start  = 1'b1;
        i_stop   = 1'b0;
        i_window = 16'(w);
        i_signal = pat(tid, 0);
        t0 = cyc;
        for (int i = 1; i <= w; i++) begin
            @(negedge clk);
            i_start = restart && (i == 2);
            if (restart && i == 2) i_window = 16'd2;
            i_stop   = (i == stop_at);
            i_signal = pat(tid, i);
        end
    endtask

    task automatic check_snaps(input string name, input int e0, input int e1, input int e2, input int e3);
        int e [4];
        e = '{e0, e1, e2, e3};
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            i_sel = 2'(s);
            #1;
            chk($sformatf("%s_sel%0d", name, s), 32'(cnt_lvl), 32'(e[s]));
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int d0;
        rst_n = 1'b0; i_start = 1'b0; i_stop = 1'b0;
        i_window = '0; i_signal = '0; i_sel = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_busy",  32'(busy_w), 32'd0);
        chk("reset_done",  32'(done_w), 32'd0);
        chk("reset_ovf",   32'(ovf_w[0]), 32'd0);
        chk("reset_count", 32'(cnt_lvl), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // level mode window of 10
        do_window(10, 0, -1, 1'b0);
        idle(2);
        chk("latency_w10", 32'(last_done_cyc - t0), 32'd11);
        check_snaps("level", 10, 5, 0, 3);
        chk("level_ovf", 32'(ovf_w[0]), 32'd0);

        // abort at sample 5: snapshots keep previous values
        d0 = done_cnt;
        do_window(10, 3, 5, 1'b0);
        idle(2);
        chk("stop5_busy", 32'(busy_w[0]), 32'd0);
        chk("stop5_nodone", 32'(done_cnt), 32'(d0));
        check_snaps("stop5", 10, 5, 0, 3);

        // edge mode, ch0 high at start then period-4 toggle
        do_window(16, 1, -1, 1'b0);
        idle(2);
        @(negedge clk); i_sel = 2'd0; #1;
        chk("edge_ch0", 32'(cnt_edge), 32'd4);
        chk("edge_level_ch0", 32'(cnt_lvl), 32'd8);

        // overflow: 20 events into 4-bit counters
        do_window(20, 2, -1, 1'b0);
        idle(2);
        @(negedge clk); i_sel = 2'd0; #1;
        chk("sat_ch0",  32'(cnt_sat),  32'd15);
        chk("wrap_ch0", 32'(cnt_wrap), 32'd4);
        chk("sat_ovf",  32'(ovf_w[2]), 32'hF);
        chk("wrap_ovf", 32'(ovf_w[3]), 32'hF);
        chk("lvl_20",   32'(cnt_lvl),  32'd20);
        chk("lvl_ovf",  32'(ovf_w[0]), 32'd0);

        // abort on the final sample edge
        d0 = done_cnt;
        do_window(20, 3, 20, 1'b0);
        idle(2);
        chk("stoplast_nodone", 32'(done_cnt), 32'(d0));
        chk("stoplast_sat", 32'(cnt_sat), 32'd15);

        // zero-length start ignored
        @(negedge clk); i_start = 1'b1; i_window = 16'd0;
        @(negedge clk); i_start = 1'b0; #1;
        chk("win0_busy", 32'(busy_w[0]), 32'd0);
        idle(2);
        chk("win0_busy2", 32'(busy_w[0]), 32'd0);

        // restart and window change during COUNT ignored
        do_window(6, 3, -1, 1'b1);
        idle(3);
        chk("restart_latency", 32'(last_done_cyc - t0), 32'd7);

        // back-to-back windows of 3, second start in the done cycle
        d0 = done_cnt;
        do_window(3, 0, -1, 1'b0);
        do_window(3, 0, -1, 1'b0);
        idle(3);
        chk("b2b_dones", 32'(done_cnt), 32'(d0 + 2));
        chk("b2b_latency", 32'(last_done_cyc - t0), 32'd4);
        check_snaps("b2b", 3, 2, 0, 3);

        // reset in the middle of a window
        @(negedge clk); i_start = 1'b1; i_window = 16'd8; i_signal = 4'hF;
        repeat (3) begin @(negedge clk); i_start = 1'b0; end
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy",  32'(busy_w), 32'd0);
        chk("rst_mid_done",  32'(done_w), 32'd0);
        chk("rst_mid_ovf",   32'(ovf_w[2]), 32'd0);
        chk("rst_mid_count", 32'(cnt_lvl), 32'd0);
        check_snaps("rst_mid", 0, 0, 0, 0);
        @(negedge clk); rst_n = 1'b1;
        idle(2);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rst_n    = ($urandom_range(0, 399) != 0);
            i_start  = ($urandom_range(0, 2) == 0);
            i_stop   = ($urandom_range(0, 59) == 0);
            i_window = 16'($urandom_range(0, 40));
            i_signal = 4'($urandom);
            i_sel    = 2'($urandom);
        end
        @(negedge clk); rst_n = 1'b1;
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
